// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, mid-bit sampling FSM with parity/stop checks,
// internal byte FIFO with sticky error flags and active-low rts flow control.
module uart_rx #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  rx,
   output logic                  rts,
   input  logic                  flow_ctrl,
   input  logic                  parity,
   input  logic                  stop_bits,
   input  logic                  data_bits,
   input  logic [23:0]           baud_reg,
   input  logic                  pop,
   output logic [7:0]            data_out,
   output logic [ADDR_WIDTH:0]   size,
   output logic                  empty,
   output logic                  full,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun
);

   // state  | meaning
   // IDLE   | waiting for falling edge on rx_s
   // START  | timing to mid start bit, glitch check
   // DATA   | sampling data bits LSB first
   // PARITY | sampling even parity bit
   // STOP   | sampling 1 or 2 stop bits, resolving the frame
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam int D = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] RTS_LVL = (ADDR_WIDTH + 1)'(D - 2);
   localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(D);

   logic rx_m, rx_s, rx_p;

   state_t      state, state_n;
   logic [24:0] cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  shift, shift_n;
   logic        fbad, fbad_n;
   logic        pbad, pbad_n;
   logic        stop_bad;
   logic        push, set_perr, set_ferr, set_ovr;

   logic [24:0] half_m1, bit_m1, two_m1;
   logic [2:0]  last_idx;

   logic [7:0]            mem [D];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  do_pop;

   assign half_m1  = {2'b00, baud_reg[23:1]} - 25'd1;
   assign bit_m1   = {1'b0, baud_reg} - 25'd1;
   assign two_m1   = {baud_reg, 1'b0} - 25'd1;
   assign last_idx = 3'd6 + {2'b00, data_bits};

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_p <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         fbad  <= 1'b0;
         pbad  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
         fbad  <= fbad_n;
         pbad  <= pbad_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt + 25'd1;
      idx_n    = idx;
      shift_n  = shift;
      fbad_n   = fbad;
      pbad_n   = pbad;
      stop_bad = 1'b0;
      push     = 1'b0;
      set_perr = 1'b0;
      set_ferr = 1'b0;
      set_ovr  = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = cnt;
            if (!rx_s && rx_p) begin
               cnt_n   = 25'd1;
               idx_n   = '0;
               shift_n = '0;
               fbad_n  = 1'b0;
               pbad_n  = 1'b0;
               state_n = S_START;
            end
         end
         S_START: begin
            if (cnt == half_m1) begin
               cnt_n   = '0;
               state_n = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == bit_m1) begin
               cnt_n          = '0;
               shift_n[idx]   = rx_s;
               if (idx == last_idx)
                  state_n = parity ? S_PARITY : S_STOP;
               else
                  idx_n = idx + 3'd1;
            end
         end
         S_PARITY: begin
            if (cnt == bit_m1) begin
               if (rx_s != ^shift)
                  pbad_n = 1'b1;
               cnt_n   = '0;
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt == bit_m1 || (stop_bits && cnt == two_m1)) begin
               stop_bad = fbad | ~rx_s;
               fbad_n   = stop_bad;
               // Leave at mid stop bit so a tight next start edge is not missed.
               if (!stop_bits || cnt == two_m1) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
                  if (stop_bad)
                     set_ferr = 1'b1;
                  else if (full)
                     set_ovr = 1'b1;
                  else begin
                     push     = 1'b1;
                     set_perr = pbad;
                  end
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (set_perr) parity_err <= 1'b1;
         if (set_ferr) frame_err  <= 1'b1;
         if (set_ovr)  overrun    <= 1'b1;
      end
   end

   assign do_pop = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear && !reset)
         mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rts <= 1'b1;
      else
         rts <= flow_ctrl && (count >= RTS_LVL);
   end

   assign data_out = mem[rd_ptr];
   assign size     = count;
   assign empty    = (count == '0);
   assign full     = (count == FULL_LVL);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a
// queue-based reference model of the receiver's externally visible behaviour.
module tb_uart_rx;
   localparam int AW = 2;
   localparam int D  = 2 ** AW;

   logic          clk = 1'b0;
   logic          reset, clear, rx, rts, flow_ctrl, parity, stop_bits, data_bits, pop;
   logic [23:0]   baud_reg;
   logic [7:0]    data_out;
   logic [AW:0]   size;
   logic          empty, full, parity_err, frame_err, overrun;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] exp_q [$];
   bit e_perr, e_ferr, e_ovr;

   uart_rx #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .clear(clear), .rx(rx), .rts(rts),
      .flow_ctrl(flow_ctrl), .parity(parity), .stop_bits(stop_bits),
      .data_bits(data_bits), .baud_reg(baud_reg), .pop(pop),
      .data_out(data_out), .size(size), .empty(empty), .full(full),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b);
      rx = b;
      idle(int'(baud_reg));
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip, input bit sbad);
      int nb;
      logic [7:0] v;
      nb = data_bits ? 8 : 7;
      v  = data_bits ? d : (d & 8'h7F);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(v[i]);
      if (parity) send_bit(($countones(v) % 2 == 1) ^ flip);
      send_bit(!sbad);
      if (stop_bits) send_bit(1'b1);
      rx = 1'b1;
      idle(6);
      if (sbad)                    e_ferr = 1'b1;
      else if (exp_q.size() == D)  e_ovr  = 1'b1;
      else begin
         exp_q.push_back(v);
         if (parity && flip) e_perr = 1'b1;
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".size"},  32'(size), 32'(exp_q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
      chk({tag, ".full"},  32'(full), 32'(exp_q.size() == D));
      chk({tag, ".perr"},  32'(parity_err), 32'(e_perr));
      chk({tag, ".ferr"},  32'(frame_err), 32'(e_ferr));
      chk({tag, ".ovr"},   32'(overrun), 32'(e_ovr));
      chk({tag, ".rts"},   32'(rts), 32'(flow_ctrl && exp_q.size() >= D - 2));
   endtask

   task automatic pop_one(input string tag);
      chk({tag, ".data"}, 32'(data_out), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      @(negedge clk);
      chk({tag, ".size"}, 32'(size), 32'(exp_q.size()));
      chk({tag, ".rts"},  32'(rts), 32'(flow_ctrl && exp_q.size() >= D - 2));
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_one(tag);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      @(negedge clk);
      chk({tag, ".empty_pop"}, 32'(size), 32'd0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      idle(2);
      exp_q.delete();
      e_perr = 0; e_ferr = 0; e_ovr = 0;
   endtask

   task automatic set_cfg(input bit p, input bit s, input bit db, input int b, input bit fc);
      parity = p; stop_bits = s; data_bits = db; baud_reg = 24'(b); flow_ctrl = fc;
      idle(2);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; rx = 1'b1; pop = 1'b0;
      flow_ctrl = 1'b0; parity = 1'b0; stop_bits = 1'b0; data_bits = 1'b1; baud_reg = 24'd16;
      e_perr = 0; e_ferr = 0; e_ovr = 0;
      idle(3);
      chk("reset.rts",   32'(rts), 32'd1);
      chk("reset.empty", 32'(empty), 32'd1);
      chk("reset.size",  32'(size), 32'd0);
      chk("reset.full",  32'(full), 32'd0);
      chk("reset.flags", 32'({parity_err, frame_err, overrun}), 32'd0);
      reset = 1'b0;
      idle(3);

      set_cfg(0, 0, 1, 16, 0);
      send_frame(8'h55, 0, 0);
      check_status("8n1");
      drain("8n1");

      set_cfg(1, 1, 0, 16, 0);
      send_frame(8'h41, 0, 0);
      check_status("7e2_a");
      send_frame(8'h41, 1, 0);
      check_status("7e2_b");
      drain("7e2");
      do_clear();
      check_status("clr");

      set_cfg(0, 0, 1, 16, 0);
      send_frame(8'hA5, 0, 1);
      check_status("ferr");
      send_frame(8'h3C, 0, 0);
      check_status("after_ferr");
      drain("after_ferr");
      do_clear();

      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      check_status("glitch");

      set_cfg(0, 0, 1, 16, 1);
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 0, 0);
         check_status($sformatf("flow%0d", k));
      end
      drain("flow");
      do_clear();

      set_cfg(0, 0, 1, 16, 0);
      send_frame(8'h11, 0, 0);
      rx = 1'b0;
      idle(16 * 3);
      reset = 1'b1;
      rx = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(4);
      exp_q.delete();
      e_perr = 0; e_ferr = 0; e_ovr = 0;
      chk("rst_mid.rts", 32'(rts), 32'd0);
      check_status("rst_mid");
      send_frame(8'hC3, 0, 0);
      check_status("rst_after");
      drain("rst_after");

      for (int g = 0; g < 8; g++) begin
         int nf;
         set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(4, 24), $urandom_range(0, 1));
         nf = $urandom_range(1, 5);
         for (int f = 0; f < nf; f++) begin
            send_frame(8'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0);
            check_status($sformatf("rnd%0d_%0d", g, f));
         end
         drain($sformatf("rnd%0d", g));
         do_clear();
         check_status($sformatf("rnd%0d_clr", g));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
